// File: rtl/serial_nibble_adder_if.sv
// Handshake bundle for serial_nibble_adder: operand channel in, result channel out.
// Both channels are valid/ready: a transfer happens on a rising edge where valid and ready are both 1.
interface serial_nibble_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         C_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         C_out;

  modport master (
    output in_valid, A, B, C_in, out_ready,
    input  in_ready, out_valid, S, C_out
  );

  modport slave (
    input  in_valid, A, B, C_in, out_ready,
    output in_ready, out_valid, S, C_out
  );
endinterface

// File: rtl/serial_nibble_adder.sv
// Bit-serial-by-nibble adder: one 4-bit ripple slice reused over NIBBLES cycles
// to compute {C_out, S} = A + B + C_in.
module serial_nibble_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_nibble_adder_if.slave bus,
  output logic [1:0]           state_dbg
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q;
  logic [W-1:0]  a_q, b_q, s_q;
  logic          carry_q, c_out_q;

  logic [3:0]    a_nib, b_nib, slice_sum;
  logic          slice_carry, c_r;

  // Shared 4-bit ripple-carry slice fed from the current nibble index.
  always_comb begin
    a_nib     = a_q[4*k_q +: 4];
    b_nib     = b_q[4*k_q +: 4];
    slice_sum = 4'd0;
    c_r       = carry_q;
    for (int i = 0; i < 4; i++) begin
      slice_sum[i] = a_nib[i] ^ b_nib[i] ^ c_r;
      c_r          = (a_nib[i] & b_nib[i]) | (c_r & (a_nib[i] ^ b_nib[i]));
    end
    slice_carry = c_r;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)   state_d = RUN;
      RUN:     if (k_q == K_LAST)  state_d = DONE;
      DONE:    if (bus.out_ready)  state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_out_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.C_in;
            k_q     <= '0;
          end
        end
        RUN: begin
          s_q[4*k_q +: 4] <= slice_sum;
          carry_q         <= slice_carry;
          // Index parks on the last nibble so it never points past the operands.
          if (k_q == K_LAST) c_out_q <= slice_carry;
          else               k_q     <= k_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.S         = s_q;
  assign bus.C_out     = c_out_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_serial_nibble_adder.sv
// Directed and random bench for serial_nibble_adder (NIBBLES=4 main instance,
// NIBBLES=1 instance for the single-slice case).
module tb_serial_nibble_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_nibble_adder_if #(.NIBBLES(4)) bus4 ();
  serial_nibble_adder_if #(.NIBBLES(1)) bus1 ();
  logic [1:0] st4, st1;

  serial_nibble_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .state_dbg(st4));
  serial_nibble_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .state_dbg(st1));

  int checks = 0;
  int errors = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
    int n = 0;
    logic [W:0] e;
    while (bus4.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send_timeout: observed in_ready=%b expected 1", bus4.in_ready);
    end
    bus4.A = a; bus4.B = b; bus4.C_in = cin; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    e = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    if (push) exp_q.push_back(e);
  endtask

  task automatic receive(input string tag, input int stall);
    int n = 0;
    logic [W:0] held, e;
    while (bus4.out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL %s_timeout: observed out_valid=%b expected 1", tag, bus4.out_valid);
      return;
    end
    held = {bus4.C_out, bus4.S};
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_extra: observed result %0h expected none", tag, held);
    end else begin
      e = exp_q.pop_front();
      check(tag, held, e);
    end
    repeat (stall) begin
      @(negedge clk);
      check({tag, "_hold"}, {bus4.out_valid, bus4.C_out, bus4.S}, {1'b1, held});
    end
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rc;
    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.A = '0; bus4.B = '0; bus4.C_in = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.A = '0; bus1.B = '0; bus1.C_in = 1'b0; bus1.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_state", st4, 2'd0);
    check("rst_outputs", {bus4.in_ready, bus4.out_valid, bus4.C_out, bus4.S}, {1'b1, 1'b0, 1'b0, 16'h0});
    rst = 1'b0;
    @(negedge clk);

    // Single-nibble instance: 7 + E = 0x15
    bus1.A = 4'b0111; bus1.B = 4'b1110; bus1.C_in = 1'b0; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("n1_run", {bus1.out_valid, bus1.in_ready}, 2'b00);
    @(negedge clk);
    check("n1_result", {bus1.out_valid, bus1.C_out, bus1.S}, {1'b1, 1'b1, 4'b0101});
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    @(negedge clk);
    check("n1_idle_retain", {bus1.in_ready, bus1.out_valid, bus1.C_out, bus1.S}, {1'b1, 1'b0, 1'b1, 4'b0101});

    // Latency: four RUN cycles, result visible after the fourth edge
    send(16'h0001, 16'h0002, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("lat_cyc%0d", i), {bus4.in_ready, bus4.out_valid}, {1'b0, (i == 4)});
    end
    receive("lat_result", 0);

    // Carry ripples across every nibble
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    receive("ripple", 1);

    // Backpressure: new operands presented while RUN and DONE must be ignored
    send(16'h00FF, 16'h0F0F, 1'b1, 1'b1);
    bus4.A = 16'hAAAA; bus4.B = 16'h5555; bus4.C_in = 1'b1; bus4.in_valid = 1'b1;
    receive("bp", 10);
    check("bp_idle_gap", {bus4.in_ready, st4}, {1'b1, 2'd0});
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    check("bp_accept", bus4.in_ready, 1'b0);
    exp_q.push_back(17'h10000);
    receive("bp_next", 0);

    // Asynchronous abort during RUN
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("abort_outputs", {bus4.in_ready, bus4.out_valid, bus4.C_out, bus4.S, st4},
          {1'b1, 1'b0, 1'b0, 16'h0, 2'd0});
    #1 rst = 1'b0;
    send(16'h8000, 16'h8000, 1'b0, 1'b1);
    receive("after_abort", 0);

    // Random operands with random result stalls
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom_range(0, 16'hFFFF));
      rb = W'($urandom_range(0, 16'hFFFF));
      rc = 1'($urandom_range(0, 1));
      if (i % 97 == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
      send(ra, rb, rc, 1'b1);
      receive("rand", $urandom_range(0, 3));
    end
    check("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
